osc_trig_ctrl: RTL and testbench
================================

// Module: osc_trig_ctrl
// PURPOSE
//  Trigger/capture sequencer for the scope acquisition path in the ad_clk domain.
//  Takes the debounced comparator pulse from the AD front end and the raw AD samples.
//  Runs pre-trigger fill, trigger search, edge/timeout triggering and post-trigger count,
//  driving the write side of a circular sample RAM.
//  Reports the record start address and completion to the Nios II GUI via PIO.
// PARAMETERS
//  ADDR_W   10      sample RAM address width; DEPTH = 2**ADDR_W
//  AUTO_TO  50000   auto-mode timeout, ad_clk cycles spent in WAIT_TRIG before a forced trigger
// PORTS
//  ad_clk      in   1       AD sample clock
//  rst_n       in   1       async reset, active-low
//  ad_data     in   8       AD sample
//  ad_pulse    in   1       debounced level-compare pulse
//  arm         in   1       1-cycle start request
//  abort       in   1       1-cycle cancel request
//  trig_edge   in   1       0 = rising, 1 = falling; latched at arm
//  auto_mode   in   1       1 = auto (timeout forces trigger); latched at arm
//  pre_len     in   ADDR_W  pre-trigger samples; latched at arm, clamped to DEPTH-1
//  wr_en       out  1       RAM write enable
//  wr_addr     out  ADDR_W  RAM write address
//  wr_data     out  8       RAM write data
//  trig_addr   out  ADDR_W  RAM address holding the trigger sample
//  start_addr  out  ADDR_W  oldest sample of record = trig_addr - pre_len (mod DEPTH)
//  busy        out  1       high in PRE_FILL, WAIT_TRIG, POST
//  done        out  1       high in DONE
//  forced      out  1       last trigger came from the auto timeout
// BEHAVIOUR
//  Reset:
//   - state = IDLE; all outputs 0; edge register (pulse_q) = 0.
//  Registered outputs:
//   - A sample is presented on ad_data at edge k.
//   - It appears on wr_data, with wr_en = 1 and wr_addr, during cycle k+1.
//   - wr_addr increments by 1 after each write and wraps DEPTH-1 -> 0.
//  Edge detect:
//   - pulse_q <= ad_pulse every cycle, in all states.
//   - rise = ad_pulse & ~pulse_q; fall = ~ad_pulse & pulse_q.
//   - The selected edge is qualified only in WAIT_TRIG.
//  FSM:
//   - IDLE: no writes.
//     - On arm: latch config, clear wr_addr, pre_cnt, to_cnt and forced.
//     - Then go to PRE_FILL, or to WAIT_TRIG if pre_len = 0.
//   - PRE_FILL: write every cycle, pre_cnt++.
//     - After pre_len writes, go to WAIT_TRIG.
//     - Edges are ignored here.
//   - WAIT_TRIG: write every cycle, to_cnt++.
//     - The cycle with a qualified edge is the trigger sample: trig_addr <= the address written by it.
//     - The same applies when auto_mode = 1 and to_cnt = AUTO_TO-1; that case also sets forced = 1.
//     - Then go to POST with post_cnt = DEPTH-1-pre_len.
//     - If post_cnt = 0, go straight to DONE.
//   - POST: write every cycle, post_cnt--.
//     - After the last write go to DONE.
//     - Total writes after the trigger sample = DEPTH-1-pre_len.
//   - DONE: wr_en = 0.
//     - trig_addr, start_addr and forced are held.
//     - On arm, start a new capture exactly as from IDLE.
//  Priorities and boundary cases:
//   - abort in any state -> IDLE next cycle, wr_en = 0. abort beats a simultaneous arm.
//   - arm in PRE_FILL, WAIT_TRIG or POST is ignored.
//   - Config inputs changing while busy have no effect.
//   - Edge and timeout in the same cycle: treat as an edge trigger, forced = 0.
//   - Normal mode (auto_mode = 0) waits indefinitely.
//   - rst_n mid-capture: immediate return to reset values; no further writes.
//  Widths:
//   - pre_cnt, post_cnt: ADDR_W bits. to_cnt: clog2(AUTO_TO) bits.
//   - Address arithmetic is modulo DEPTH.
// TESTING (bench: ADDR_W=4, AUTO_TO=20)
//  1. pre_len=4, rising edge on the 10th written sample
//     -> trig_addr=9, start_addr=5, 11 POST writes (addr 10..15, 0..4), done=1, forced=0.
//  2. trig_edge=1, pre_len=0, ad_pulse falls on the 3rd written sample
//     -> trig_addr=2, start_addr=2, 15 post writes, done.
//  3. auto_mode=1, ad_pulse held at 0
//     -> forced trigger after 20 WAIT_TRIG cycles, forced=1, done.
//     -> Repeat with auto_mode=0 -> stays in WAIT_TRIG.
//  4. Edge during PRE_FILL (pre_len=8) -> ignored; trigger taken only after 8 writes.
//  5. abort in POST -> IDLE next cycle, wr_en=0.
//     -> arm+abort in the same cycle -> stays IDLE.
//     -> arm in WAIT_TRIG -> ignored.
//  6. rst_n low mid-POST -> all outputs 0; after release, arm starts clean at wr_addr=0.

Source files
------------

// File: rtl/osc_trig_if.sv
// Capture-side bus of the scope trigger sequencer: sample RAM write port
// plus the record/status words read back by the GUI over PIO.
interface osc_trig_if #(
   parameter int ADDR_W = 10
);
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        wr_data;
   logic [ADDR_W-1:0] trig_addr;
   logic [ADDR_W-1:0] start_addr;
   logic              busy;
   logic              done;
   logic              forced;

   modport master (
      output wr_en, wr_addr, wr_data, trig_addr, start_addr, busy, done, forced
   );

   modport slave (
      input wr_en, wr_addr, wr_data, trig_addr, start_addr, busy, done, forced
   );
endinterface

// File: rtl/osc_trig_ctrl.sv
// Trigger/capture sequencer: pre-trigger fill, edge or auto-timeout trigger search
// and post-trigger count, writing AD samples into a circular sample RAM.
module osc_trig_ctrl #(
   parameter int ADDR_W  = 10,
   parameter int AUTO_TO = 50000
) (
   input  logic              ad_clk,
   input  logic              rst_n,
   input  logic [7:0]        ad_data,
   input  logic              ad_pulse,
   input  logic              arm,
   input  logic              abort,
   input  logic              trig_edge,
   input  logic              auto_mode,
   input  logic [ADDR_W-1:0] pre_len,
   osc_trig_if.master        cap
);
   localparam int TO_W = (AUTO_TO > 1) ? $clog2(AUTO_TO) : 1;
   localparam logic [ADDR_W-1:0] ZERO_A    = {ADDR_W{1'b0}};
   localparam logic [ADDR_W-1:0] ONE_A     = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
   localparam logic [TO_W-1:0]   TO_ZERO   = {TO_W{1'b0}};
   localparam logic [TO_W-1:0]   TO_ONE    = TO_W'(1);
   localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(AUTO_TO - 1);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_PRE_FILL  = 3'd1,
      ST_WAIT_TRIG = 3'd2,
      ST_POST      = 3'd3,
      ST_DONE      = 3'd4
   } state_t;

   state_t            state_r;
   state_t            state_s;
   logic              pulse_q_r;
   logic              edge_cfg_r;
   logic              auto_cfg_r;
   logic [ADDR_W-1:0] pre_len_cfg_r;
   logic [ADDR_W-1:0] pre_cnt_r;
   logic [ADDR_W-1:0] post_cnt_r;
   logic [ADDR_W-1:0] wr_ptr_r;
   logic [TO_W-1:0]   to_cnt_r;
   logic              wr_en_r;
   logic [ADDR_W-1:0] wr_addr_r;
   logic [7:0]        wr_data_r;
   logic [ADDR_W-1:0] trig_addr_r;
   logic [ADDR_W-1:0] start_addr_r;
   logic              busy_r;
   logic              done_r;
   logic              forced_r;

   logic              rise_s;
   logic              fall_s;
   logic              in_wait_s;
   logic              edge_hit_s;
   logic              timeout_s;
   logic              trig_s;
   logic              start_s;
   logic              write_s;
   logic [ADDR_W-1:0] post_len_s;

   assign rise_s     = ad_pulse & ~pulse_q_r;
   assign fall_s     = ~ad_pulse & pulse_q_r;
   assign in_wait_s  = (state_r == ST_WAIT_TRIG);
   assign edge_hit_s = in_wait_s & (edge_cfg_r ? fall_s : rise_s);
   assign timeout_s  = in_wait_s & auto_cfg_r & (to_cnt_r == TO_LAST);
   assign trig_s     = edge_hit_s | timeout_s;
   assign start_s    = arm & ~abort & ((state_r == ST_IDLE) | (state_r == ST_DONE));
   assign write_s    = ~abort & ((state_r == ST_PRE_FILL) | in_wait_s | (state_r == ST_POST));
   // Writes still owed after the trigger sample so the record fills the whole RAM
   assign post_len_s = LAST_ADDR - pre_len_cfg_r;

   // Next-state decode; abort overrides every other request
   always_comb begin
      state_s = state_r;
      if (abort) begin
         state_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE, ST_DONE: begin
               if (arm) begin
                  state_s = (pre_len == ZERO_A) ? ST_WAIT_TRIG : ST_PRE_FILL;
               end else begin
                  state_s = state_r;
               end
            end
            ST_PRE_FILL: begin
               if (pre_cnt_r == (pre_len_cfg_r - ONE_A)) begin
                  state_s = ST_WAIT_TRIG;
               end else begin
                  state_s = ST_PRE_FILL;
               end
            end
            ST_WAIT_TRIG: begin
               if (trig_s) begin
                  state_s = (post_len_s == ZERO_A) ? ST_DONE : ST_POST;
               end else begin
                  state_s = ST_WAIT_TRIG;
               end
            end
            ST_POST: begin
               if (post_cnt_r == ONE_A) begin
                  state_s = ST_DONE;
               end else begin
                  state_s = ST_POST;
               end
            end
            default: state_s = ST_IDLE;
         endcase
      end
   end

   // State register, edge history and registered status flags
   always_ff @(posedge ad_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= ST_IDLE;
         pulse_q_r <= 1'b0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         state_r   <= state_s;
         pulse_q_r <= ad_pulse;
         busy_r    <= (state_s == ST_PRE_FILL) | (state_s == ST_WAIT_TRIG) | (state_s == ST_POST);
         done_r    <= (state_s == ST_DONE);
      end
   end

   // RAM write port: the sample seen at this edge is written during the next cycle
   always_ff @(posedge ad_clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_en_r   <= 1'b0;
         wr_addr_r <= ZERO_A;
         wr_data_r <= 8'h00;
         wr_ptr_r  <= ZERO_A;
      end else begin
         wr_en_r <= write_s;
         if (start_s) begin
            wr_addr_r <= ZERO_A;
            wr_ptr_r  <= ZERO_A;
         end else if (write_s) begin
            wr_addr_r <= wr_ptr_r;
            wr_data_r <= ad_data;
            wr_ptr_r  <= wr_ptr_r + ONE_A;
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end
      end
   end

   // Configuration latch, phase counters and the trigger record
   always_ff @(posedge ad_clk or negedge rst_n) begin
      if (!rst_n) begin
         edge_cfg_r    <= 1'b0;
         auto_cfg_r    <= 1'b0;
         pre_len_cfg_r <= ZERO_A;
         pre_cnt_r     <= ZERO_A;
         post_cnt_r    <= ZERO_A;
         to_cnt_r      <= TO_ZERO;
         trig_addr_r   <= ZERO_A;
         start_addr_r  <= ZERO_A;
         forced_r      <= 1'b0;
      end else if (start_s) begin
         edge_cfg_r    <= trig_edge;
         auto_cfg_r    <= auto_mode;
         pre_len_cfg_r <= pre_len;
         pre_cnt_r     <= ZERO_A;
         to_cnt_r      <= TO_ZERO;
         forced_r      <= 1'b0;
      end else if (write_s) begin
         case (state_r)
            ST_PRE_FILL: pre_cnt_r <= pre_cnt_r + ONE_A;
            ST_WAIT_TRIG: begin
               to_cnt_r <= to_cnt_r + TO_ONE;
               if (trig_s) begin
                  trig_addr_r  <= wr_ptr_r;
                  start_addr_r <= wr_ptr_r - pre_len_cfg_r;
                  forced_r     <= timeout_s & ~edge_hit_s;
                  post_cnt_r   <= post_len_s;
               end else begin
                  post_cnt_r <= post_cnt_r;
               end
            end
            ST_POST: post_cnt_r <= post_cnt_r - ONE_A;
            default: post_cnt_r <= post_cnt_r;
         endcase
      end else begin
         to_cnt_r <= to_cnt_r;
      end
   end

   assign cap.wr_en      = wr_en_r;
   assign cap.wr_addr    = wr_addr_r;
   assign cap.wr_data    = wr_data_r;
   assign cap.trig_addr  = trig_addr_r;
   assign cap.start_addr = start_addr_r;
   assign cap.busy       = busy_r;
   assign cap.done       = done_r;
   assign cap.forced     = forced_r;
endmodule

// File: tb/tb_osc_trig_ctrl.sv
// Directed bench for osc_trig_ctrl (ADDR_W=4, AUTO_TO=20): table of full captures
// plus hand-written abort, re-arm and mid-capture reset sequences.
module tb_osc_trig_ctrl;
   localparam int ADDR_W = 4;

   logic              ad_clk = 1'b0;
   logic              rst_n;
   logic [7:0]        ad_data;
   logic              ad_pulse;
   logic              arm;
   logic              abort;
   logic              trig_edge;
   logic              auto_mode;
   logic [ADDR_W-1:0] pre_len;

   int checks = 0;
   int errors = 0;

   osc_trig_if #(.ADDR_W(ADDR_W)) cap_if ();

   osc_trig_ctrl #(.ADDR_W(ADDR_W), .AUTO_TO(20)) dut (
      .ad_clk    (ad_clk),
      .rst_n     (rst_n),
      .ad_data   (ad_data),
      .ad_pulse  (ad_pulse),
      .arm       (arm),
      .abort     (abort),
      .trig_edge (trig_edge),
      .auto_mode (auto_mode),
      .pre_len   (pre_len),
      .cap       (cap_if)
   );

   always #5 ad_clk = ~ad_clk;

   typedef struct {
      logic       trg_edge;
      logic       auto_m;
      logic [3:0] pre;
      int         on1;
      int         off1;
      int         on2;
      int         exp_trig;
      int         exp_start;
      int         exp_forced;
      int         exp_writes;
   } vec_t;

   vec_t vecs [6];

   task automatic step();
      @(posedge ad_clk);
      #1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Comparator level for write index idx; the active window is inverted for falling-edge runs
   function automatic logic lvl(input vec_t v, input int idx);
      logic act;
      act = ((idx >= v.on1) && (idx < v.off1)) || (idx >= v.on2);
      return act ^ v.trg_edge;
   endfunction

   task automatic run_vec(input int n, input vec_t v);
      int   nwr;
      logic got_done;
      trig_edge = v.trg_edge;
      auto_mode = v.auto_m;
      pre_len   = v.pre;
      ad_pulse  = lvl(v, -1);
      arm       = 1'b1;
      step();
      arm = 1'b0;
      check("arm_busy", cap_if.busy, 1);
      // Config scrambled while busy must not matter
      trig_edge = ~v.trg_edge;
      auto_mode = 1'b1;
      pre_len   = ~v.pre;
      nwr       = 0;
      got_done  = 1'b0;
      for (int idx = 0; idx < 200 && !got_done; idx++) begin
         ad_data  = 8'((idx * 7 + n * 16 + 3) % 256);
         ad_pulse = lvl(v, idx);
         step();
         if (cap_if.wr_en) begin
            check("wr_addr", cap_if.wr_addr, nwr % 16);
            check("wr_data", cap_if.wr_data, (nwr * 7 + n * 16 + 3) % 256);
            nwr++;
         end
         got_done = cap_if.done;
         if (!got_done) check("busy_run", cap_if.busy, 1);
      end
      check("reached_done", got_done, 1);
      check("total_writes", nwr, v.exp_writes);
      check("trig_addr", cap_if.trig_addr, v.exp_trig);
      check("start_addr", cap_if.start_addr, v.exp_start);
      check("forced", cap_if.forced, v.exp_forced);
      check("busy_done", cap_if.busy, 0);
      step();
      check("done_wr_en", cap_if.wr_en, 0);
      check("done_held", cap_if.done, 1);
      check("trig_held", cap_if.trig_addr, v.exp_trig);
   endtask

   initial begin
      //          edge  auto  pre    on1   off1  on2   trig start frc writes
      vecs[0] = '{1'b0, 1'b0, 4'd4,  9,    1000, 1000, 9,   5,    0,  21};
      vecs[1] = '{1'b1, 1'b0, 4'd0,  2,    1000, 1000, 2,   2,    0,  18};
      vecs[2] = '{1'b0, 1'b1, 4'd0,  1000, 1000, 1000, 3,   3,    1,  35};
      vecs[3] = '{1'b0, 1'b0, 4'd8,  3,    5,    10,   10,  2,    0,  18};
      vecs[4] = '{1'b0, 1'b0, 4'd15, 20,   1000, 1000, 4,   5,    0,  21};
      vecs[5] = '{1'b0, 1'b1, 4'd0,  19,   1000, 1000, 3,   3,    0,  35};

      rst_n = 1'b0; ad_data = 8'h00; ad_pulse = 1'b0; arm = 1'b0; abort = 1'b0;
      trig_edge = 1'b0; auto_mode = 1'b0; pre_len = 4'd0;
      step(); step();
      check("rst_wr_en", cap_if.wr_en, 0);
      check("rst_wr_addr", cap_if.wr_addr, 0);
      check("rst_busy", cap_if.busy, 0);
      check("rst_done", cap_if.done, 0);
      check("rst_forced", cap_if.forced, 0);
      rst_n = 1'b1;
      step();

      for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

      // Normal mode with no edge waits indefinitely; arm while waiting is ignored
      trig_edge = 1'b0; auto_mode = 1'b0; pre_len = 4'd0; ad_pulse = 1'b0; arm = 1'b1;
      step();
      arm = 1'b0;
      step(); step(); step();
      check("wait_addr", cap_if.wr_addr, 2);
      arm = 1'b1; pre_len = 4'd5;
      step();
      arm = 1'b0;
      check("arm_in_wait_addr", cap_if.wr_addr, 3);
      check("arm_in_wait_busy", cap_if.busy, 1);
      repeat (40) step();
      check("normal_no_timeout_done", cap_if.done, 0);
      check("normal_no_timeout_busy", cap_if.busy, 1);
      check("normal_wr_addr", cap_if.wr_addr, 43 % 16);
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("abort_wait_busy", cap_if.busy, 0);

      // Abort in POST, then arm+abort together stays idle
      pre_len = 4'd0; ad_pulse = 1'b0; arm = 1'b1;
      step();
      arm = 1'b0; ad_pulse = 1'b1;
      step(); step(); step();
      check("post_busy", cap_if.busy, 1);
      check("post_trig", cap_if.trig_addr, 0);
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("abort_post_wr_en", cap_if.wr_en, 0);
      check("abort_post_busy", cap_if.busy, 0);
      check("abort_post_done", cap_if.done, 0);
      arm = 1'b1; abort = 1'b1;
      step();
      arm = 1'b0; abort = 1'b0;
      check("arm_abort_busy", cap_if.busy, 0);
      step();
      check("arm_abort_wr_en", cap_if.wr_en, 0);
      check("arm_abort_busy2", cap_if.busy, 0);

      // Reset mid-POST, then a clean restart
      pre_len = 4'd3; ad_pulse = 1'b0; arm = 1'b1;
      step();
      arm = 1'b0;
      repeat (5) step();
      ad_pulse = 1'b1;
      step(); step(); step();
      check("pre_rst_trig", cap_if.trig_addr, 5);
      check("pre_rst_start", cap_if.start_addr, 2);
      #3;
      rst_n = 1'b0;
      #1;
      check("midrst_wr_en", cap_if.wr_en, 0);
      check("midrst_wr_addr", cap_if.wr_addr, 0);
      check("midrst_wr_data", cap_if.wr_data, 0);
      check("midrst_busy", cap_if.busy, 0);
      check("midrst_trig", cap_if.trig_addr, 0);
      check("midrst_start", cap_if.start_addr, 0);
      step();
      check("midrst_hold_wr_en", cap_if.wr_en, 0);
      rst_n = 1'b1;
      ad_pulse = 1'b0; ad_data = 8'hA5; pre_len = 4'd0; arm = 1'b1;
      step();
      arm = 1'b0;
      check("restart_busy", cap_if.busy, 1);
      step();
      check("restart_wr_en", cap_if.wr_en, 1);
      check("restart_wr_addr", cap_if.wr_addr, 0);
      check("restart_wr_data", cap_if.wr_data, 165);
      abort = 1'b1;
      step();
      abort = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
